alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter_alu_core.sv | 42 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding and the ALU control code map.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_ADD  = 4'h0;
    localparam logic [3:0] CTRL_SUB  = 4'h1;
    localparam logic [3:0] CTRL_AND  = 4'h2;
    localparam logic [3:0] CTRL_OR   = 4'h3;
    localparam logic [3:0] CTRL_SLL  = 4'h4;
    localparam logic [3:0] CTRL_SRL  = 4'h5;
    localparam logic [3:0] CTRL_SRA  = 4'h6;
    localparam logic [3:0] CTRL_SLT  = 4'h7;
    localparam logic [3:0] CTRL_SLTU = 4'h8;
    localparam logic [3:0] CTRL_XOR  = 4'h9;
    localparam logic [3:0] CTRL_MAX  = 4'h9;

    function automatic logic ctrl_legal(input logic [3:0] ctrl);
        return ctrl <= CTRL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bus of the ALU arbiter. Every channel is valid/ready:
// a transfer happens on a rising edge where both valid and ready are high.
interface alu_arbiter_if #(parameter int DATA_WIDTH = 32);
    import alu_arbiter_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_op1;
    logic [DATA_WIDTH-1:0] req0_op2;
    logic [3:0]            req0_ctrl;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_op1;
    logic [DATA_WIDTH-1:0] req1_op2;
    logic [3:0]            req1_ctrl;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_eq;
    logic                  rsp_err;
    logic                  busy;
    state_t                dbg_state;

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl,
        output req1_valid, req1_op1, req1_op2, req1_ctrl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_eq, rsp_err, busy, dbg_state
    );

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_eq, rsp_err, busy, dbg_state
    );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Combinational ALU shared by both requesters. Illegal control codes
// force a zero result and a cleared eq flag.
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [3:0]            ctrl,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  eq,
    output logic                  err
);

    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] shamt;

    assign shamt = op2[SW-1:0];

    always_comb begin
        result = '0;
        unique case (ctrl)
            CTRL_ADD:  result = op1 + op2;
            CTRL_SUB:  result = op1 - op2;
            CTRL_AND:  result = op1 & op2;
            CTRL_OR:   result = op1 | op2;
            CTRL_SLL:  result = op1 << shamt;
            CTRL_SRL:  result = op1 >> shamt;
            CTRL_SRA:  result = DATA_WIDTH'($signed(op1) >>> shamt);
            CTRL_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            CTRL_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, op1 < op2};
            CTRL_XOR:  result = op1 ^ op2;
            default:   result = '0;
        endcase
    end

    assign err = !ctrl_legal(ctrl);
    assign eq  = !err && (op1 == op2);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    state_t                state, state_nxt;
    logic                  prio;
    logic                  grant_id;
    logic                  any_valid;
    logic                  hs;
    logic                  lat_id;
    logic [DATA_WIDTH-1:0] lat_op1, lat_op2;
    logic [3:0]            lat_ctrl;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_eq, alu_err;
    logic                  rsp_id_q, rsp_eq_q, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic                  ready0, ready1, rsp_valid_c, busy_c;

    // Contention goes to prio; a lone requester is granted regardless of prio.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant_id  = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
    assign hs        = (state == ST_IDLE) & any_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (any_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready0      = 1'b0;
        ready1      = 1'b0;
        rsp_valid_c = 1'b0;
        busy_c      = (state != ST_IDLE);
        if (state == ST_IDLE) begin
            ready0 = bus.req0_valid & ~grant_id;
            ready1 = bus.req1_valid &  grant_id;
        end
        if (state == ST_RESP) rsp_valid_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio         <= 1'b0;
            lat_id       <= 1'b0;
            lat_op1      <= '0;
            lat_op2      <= '0;
            lat_ctrl     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_eq_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (hs) begin
                lat_id   <= grant_id;
                lat_op1  <= grant_id ? bus.req1_op1  : bus.req0_op1;
                lat_op2  <= grant_id ? bus.req1_op2  : bus.req0_op2;
                lat_ctrl <= grant_id ? bus.req1_ctrl : bus.req0_ctrl;
                prio     <= ~grant_id;
            end
            // Response registers only move at the end of EXEC, so they stay frozen in RESP.
            if (state == ST_EXEC) begin
                rsp_id_q     <= lat_id;
                rsp_result_q <= alu_result;
                rsp_eq_q     <= alu_eq;
                rsp_err_q    <= alu_err;
            end
        end
    end

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu_core (
        .op1    (lat_op1),
        .op2    (lat_op2),
        .ctrl   (lat_ctrl),
        .result (alu_result),
        .eq     (alu_eq),
        .err    (alu_err)
    );

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_eq     = rsp_eq_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_c;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant order, latency, response hold,
// illegal codes and reset behaviour, with hand-computed expectations.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int RW = W + 3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [RW-1:0] exp_q[$];

    alu_arbiter_if #(.DATA_WIDTH(W)) bus ();

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", tag, got, exp);
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_reqs();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_fields", {bus.rsp_id, bus.rsp_eq, bus.rsp_err, bus.rsp_result}, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        rst_n = 1'b1;
    endtask

    // driver: present one or two requests, follow the granted one to acceptance
    task automatic run_op(input bit v0, input bit v1,
                          input logic [3:0] c0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [3:0] c1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input bit exp_id, input logic [W-1:0] exp_res,
                          input bit exp_eq, input bit exp_err, input int hold);
        logic [RW-1:0] got;
        logic [RW-1:0] held;
        bit seen;
        @(posedge clk); #1;
        bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_op1 = a0; bus.req0_op2 = b0;
        bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_op1 = a1; bus.req1_op2 = b1;
        exp_q.push_back({exp_id, exp_eq, exp_err, exp_res});
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            seen = bus.req0_ready | bus.req1_ready;
        end
        check("grant_seen", seen, 1);
        if (!seen) begin
            clear_reqs();
            void'(exp_q.pop_front());
            return;
        end
        check("grant_ready", {bus.req1_ready, bus.req0_ready}, exp_id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        clear_reqs();
        @(negedge clk);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("exec_busy", bus.busy, 1);
        @(negedge clk);
        check("rsp_valid_c2", bus.rsp_valid, 1);
        got = {bus.rsp_id, bus.rsp_eq, bus.rsp_err, bus.rsp_result};
        check("rsp_fields", got, exp_q.pop_front());
        if (hold > 0) begin
            held = got;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_fields", {bus.rsp_id, bus.rsp_eq, bus.rsp_err, bus.rsp_result}, held);
                check("hold_valid", bus.rsp_valid, 1);
                check("hold_readies", {bus.req1_ready, bus.req0_ready}, 2'b00);
                check("hold_busy", bus.busy, 1);
            end
        end
        bus.rsp_ready = 1'b1;
        check("accept_no_grant", {bus.req1_ready, bus.req0_ready}, 2'b00);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        clear_reqs();
        @(negedge clk);
        check("post_accept_busy", bus.busy, 0);
        check("post_accept_valid", bus.rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req0_ctrl = '0; bus.req0_op1 = '0; bus.req0_op2 = '0;
        bus.req1_ctrl = '0; bus.req1_op1 = '0; bus.req1_op2 = '0;
        clear_reqs();
        do_reset();

        // round robin from reset: 0, 1, 0
        run_op(1, 1, CTRL_ADD, 32'd1, 32'd2, CTRL_ADD, 32'd10, 32'd20, 0, 32'd3,  0, 0, 0);
        run_op(1, 1, CTRL_ADD, 32'd1, 32'd2, CTRL_ADD, 32'd10, 32'd20, 1, 32'd30, 0, 0, 0);
        run_op(1, 1, CTRL_ADD, 32'd1, 32'd2, CTRL_ADD, 32'd10, 32'd20, 0, 32'd3,  0, 0, 0);

        run_op(1, 0, CTRL_ADD, 32'd5, 32'd7, CTRL_ADD, 32'd0, 32'd0, 0, 32'd12, 0, 0, 0);
        run_op(0, 1, CTRL_ADD, 32'd0, 32'd0, CTRL_SUB, 32'h55, 32'h55, 1, 32'd0, 1, 0, 0);
        run_op(0, 1, CTRL_ADD, 32'd0, 32'd0, CTRL_SUB, 32'h56, 32'h55, 1, 32'd1, 0, 0, 0);
        run_op(1, 0, CTRL_ADD, 32'hFFFF_FFFF, 32'd2, CTRL_ADD, 32'd0, 32'd0, 0, 32'd1, 0, 0, 0);
        run_op(1, 0, CTRL_SLL, 32'd1, 32'd4, CTRL_ADD, 32'd0, 32'd0, 0, 32'd16, 0, 0, 0);
        run_op(1, 0, CTRL_SRA, 32'h8000_0000, 32'd4, CTRL_ADD, 32'd0, 32'd0, 0, 32'hF800_0000, 0, 0, 0);
        run_op(0, 1, CTRL_ADD, 32'd0, 32'd0, CTRL_SLT, 32'hFFFF_FFFF, 32'd0, 1, 32'd1, 0, 0, 0);
        run_op(0, 1, CTRL_ADD, 32'd0, 32'd0, CTRL_SLTU, 32'hFFFF_FFFF, 32'd0, 1, 32'd0, 0, 0, 0);
        run_op(1, 0, CTRL_AND, 32'hF0F0, 32'hFF00, CTRL_ADD, 32'd0, 32'd0, 0, 32'hF000, 0, 0, 0);

        // response held for 5 cycles with both requesters pending
        run_op(1, 0, CTRL_XOR, 32'hF0, 32'h0F, CTRL_ADD, 32'd0, 32'd0, 0, 32'hFF, 0, 0, 5);

        // illegal control codes
        run_op(1, 0, 4'hF, 32'd3, 32'd3, CTRL_ADD, 32'd0, 32'd0, 0, 32'd0, 0, 1, 0);
        run_op(0, 1, CTRL_ADD, 32'd0, 32'd0, 4'hA, 32'd9, 32'd9, 1, 32'd0, 0, 1, 0);

        // reset while in EXEC
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_ctrl = CTRL_ADD; bus.req0_op1 = 32'd1; bus.req0_op2 = 32'd1;
        @(negedge clk);
        check("rstexec_grant", bus.req0_ready, 1);
        @(posedge clk); #1;
        clear_reqs();
        @(negedge clk);
        check("rstexec_in_exec", bus.dbg_state, ST_EXEC);
        rst_n = 1'b0;
        #1;
        check("rstexec_rsp_valid", bus.rsp_valid, 0);
        check("rstexec_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstexec_no_rsp", bus.rsp_valid, 0);
            check("rstexec_idle", bus.busy, 0);
        end

        // priority back at requester 0 after reset
        run_op(1, 1, CTRL_OR, 32'h0F, 32'hF0, CTRL_ADD, 32'd0, 32'd0, 0, 32'hFF, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
